// File: rtl/tff_bank_sequencer.sv
// Arbitrated sequencer for a bank of T flip-flops: each granted request becomes a
// one-cycle toggle vector (load = data ^ q, toggle = data) applied to the bank.
module tff_bank_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             mode0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             mode1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             grant_id,
    output logic             busy,
    output logic [WIDTH-1:0] t_mask,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_inverse,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StAck
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_last_grant;
    logic               r_grant_id;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_t_mask;
    logic [CNT_W-1:0]   r_done_count;

    logic               w_grant_valid;
    logic               w_grant_sel;
    logic               w_mode_sel;
    logic [WIDTH-1:0]   w_data_sel;
    logic               w_last_next;
    logic               w_grant_id_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_t_mask_next;
    logic [CNT_W-1:0]   w_done_next;

    // On a tie the requester not granted last wins; a lone request wins outright.
    assign w_grant_valid = req0 | req1;
    assign w_grant_sel   = (req0 && req1) ? ~r_last_grant : req1;
    assign w_mode_sel    = w_grant_sel ? mode1 : mode0;
    assign w_data_sel    = w_grant_sel ? data1 : data0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_last_next     = r_last_grant;
        w_grant_id_next = r_grant_id;
        w_q_next        = r_q;
        w_t_mask_next   = r_t_mask;
        w_done_next     = r_done_count;
        unique case (r_state)
            StIdle: begin
                if (w_grant_valid) begin
                    w_t_mask_next   = w_mode_sel ? w_data_sel : (w_data_sel ^ r_q);
                    w_grant_id_next = w_grant_sel;
                    w_last_next     = w_grant_sel;
                    w_state_next    = StApply;
                end
            end
            StApply: begin
                // The only path by which the bank changes: T cells toggle where mask=1.
                w_q_next      = r_q ^ r_t_mask;
                w_t_mask_next = '0;
                w_state_next  = StAck;
            end
            StAck: begin
                w_done_next  = r_done_count + CNT_W'(1);
                w_state_next = StIdle;
            end
            default: begin
                w_t_mask_next = '0;
                w_state_next  = StIdle;
            end
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_q          <= '0;
            r_t_mask     <= '0;
            r_done_count <= '0;
        end else begin
            r_last_grant <= w_last_next;
            r_grant_id   <= w_grant_id_next;
            r_q          <= w_q_next;
            r_t_mask     <= w_t_mask_next;
            r_done_count <= w_done_next;
        end
    end

    assign ack0       = (r_state == StAck) && !r_grant_id;
    assign ack1       = (r_state == StAck) && r_grant_id;
    assign busy       = (r_state != StIdle);
    assign grant_id   = r_grant_id;
    assign t_mask     = r_t_mask;
    assign q          = r_q;
    assign q_inverse  = ~r_q;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed self-checking bench for tff_bank_sequencer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_tff_bank_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req0, mode0, req1, mode1;
    logic [WIDTH-1:0] data0, data1;
    logic             ack0, ack1, grant_id, busy;
    logic [WIDTH-1:0] t_mask, q, q_inverse;
    logic [CNT_W-1:0] done_count;

    int n_cmp;
    int n_err;

    tff_bank_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .mode0     (mode0),
        .data0     (data0),
        .req1      (req1),
        .mode1     (mode1),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .grant_id  (grant_id),
        .busy      (busy),
        .t_mask    (t_mask),
        .q         (q),
        .q_inverse (q_inverse),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issues one transaction from an IDLE falling edge and returns
    // at the falling edge of the following IDLE cycle.
    task automatic run_txn(input bit sel, input bit mode, input logic [WIDTH-1:0] data);
        if (sel) begin req1 = 1'b1; mode1 = mode; data1 = data; end
        else     begin req0 = 1'b1; mode0 = mode; data0 = data; end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q: got %b want 0000", q); end
        n_cmp++; if (q_inverse !== 4'b1111) begin n_err++; $display("FAIL reset_qinv: got %b want 1111", q_inverse); end
        n_cmp++; if (t_mask !== 4'b0000) begin n_err++; $display("FAIL reset_tmask: got %b want 0000", t_mask); end
        n_cmp++; if ({ack0, ack1, busy, grant_id} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {ack0, ack1, busy, grant_id}); end
        n_cmp++; if (done_count !== 8'd0) begin n_err++; $display("FAIL reset_done: got %0d want 0", done_count); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_load();
        req0 = 1'b1; mode0 = 1'b0; data0 = 4'b1010;
        @(negedge clk);  // APPLY
        req0 = 1'b0;
        n_cmp++; if (t_mask !== 4'b1010) begin n_err++; $display("FAIL load_tmask: got %b want 1010", t_mask); end
        n_cmp++; if ({busy, ack0, ack1} !== 3'b100) begin n_err++; $display("FAIL load_apply_ctl: got %b want 100", {busy, ack0, ack1}); end
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL load_q_in_apply: got %b want 0000", q); end
        @(negedge clk);  // ACK
        n_cmp++; if (q !== 4'b1010 || q_inverse !== 4'b0101) begin n_err++; $display("FAIL load_q: got %b/%b want 1010/0101", q, q_inverse); end
        n_cmp++; if ({ack0, ack1, busy} !== 3'b101) begin n_err++; $display("FAIL load_ack: got %b want 101", {ack0, ack1, busy}); end
        n_cmp++; if (t_mask !== 4'b0000) begin n_err++; $display("FAIL load_tmask_clear: got %b want 0000", t_mask); end
        @(negedge clk);  // IDLE
        n_cmp++; if (done_count !== 8'd1) begin n_err++; $display("FAIL load_done: got %0d want 1", done_count); end
        n_cmp++; if ({ack0, busy} !== 2'b00) begin n_err++; $display("FAIL load_ack_pulse: got %b want 00", {ack0, busy}); end
    endtask

    task automatic test_toggle();
        req1 = 1'b1; mode1 = 1'b1; data1 = 4'b0011;
        @(negedge clk);
        req1 = 1'b0;
        n_cmp++; if (t_mask !== 4'b0011) begin n_err++; $display("FAIL toggle_tmask: got %b want 0011", t_mask); end
        n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL toggle_gid: got %b want 1", grant_id); end
        @(negedge clk);
        n_cmp++; if (q !== 4'b1001 || q_inverse !== 4'b0110) begin n_err++; $display("FAIL toggle_q: got %b/%b want 1001/0110", q, q_inverse); end
        n_cmp++; if ({ack0, ack1} !== 2'b01) begin n_err++; $display("FAIL toggle_ack: got %b want 01", {ack0, ack1}); end
        @(negedge clk);
        n_cmp++; if (done_count !== 8'd2) begin n_err++; $display("FAIL toggle_done: got %0d want 2", done_count); end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_t [4];
        logic [WIDTH-1:0] exp_qa [4];
        exp_t[0] = 4'b0001; exp_t[1] = 4'b0011; exp_t[2] = 4'b0011; exp_t[3] = 4'b0011;
        exp_qa[0] = 4'b0001; exp_qa[1] = 4'b0010; exp_qa[2] = 4'b0001; exp_qa[3] = 4'b0010;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; mode0 = 1'b0; data0 = 4'b0001;
        req1 = 1'b1; mode1 = 1'b0; data1 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);  // APPLY
            n_cmp++; if (grant_id !== i[0]) begin n_err++; $display("FAIL rr_gid[%0d]: got %b want %b", i, grant_id, i[0]); end
            n_cmp++; if (t_mask !== exp_t[i]) begin n_err++; $display("FAIL rr_tmask[%0d]: got %b want %b", i, t_mask, exp_t[i]); end
            @(negedge clk);  // ACK
            n_cmp++; if ({ack0, ack1} !== {~i[0], i[0]}) begin n_err++; $display("FAIL rr_ack[%0d]: got %b want %b", i, {ack0, ack1}, {~i[0], i[0]}); end
            exp_q = exp_qa[i];
            n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL rr_q[%0d]: got %b want %b", i, q, exp_q); end
            @(negedge clk);  // IDLE
            n_cmp++; if ({busy, ack0, ack1} !== 3'b000) begin n_err++; $display("FAIL rr_idle[%0d]: got %b want 000", i, {busy, ack0, ack1}); end
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        n_cmp++; if (done_count !== 8'd4) begin n_err++; $display("FAIL rr_done: got %0d want 4", done_count); end
    endtask

    task automatic test_null_load();
        run_txn(1'b0, 1'b0, 4'b0110);  // q 0010 -> 0110
        n_cmp++; if (q !== 4'b0110) begin n_err++; $display("FAIL null_prep_q: got %b want 0110", q); end
        req0 = 1'b1; mode0 = 1'b0; data0 = 4'b0110;
        @(negedge clk);
        req0 = 1'b0;
        n_cmp++; if ({busy, t_mask} !== 5'b10000) begin n_err++; $display("FAIL null_tmask: got %b want 10000", {busy, t_mask}); end
        @(negedge clk);
        n_cmp++; if ({ack0, q} !== 5'b10110) begin n_err++; $display("FAIL null_ack_q: got %b want 10110", {ack0, q}); end
        @(negedge clk);
        n_cmp++; if (done_count !== 8'd6) begin n_err++; $display("FAIL null_done: got %0d want 6", done_count); end
    endtask

    task automatic test_reset_mid_op();
        req1 = 1'b1; mode1 = 1'b0; data1 = 4'b1001;
        @(negedge clk);  // APPLY
        n_cmp++; if (t_mask !== 4'b1111) begin n_err++; $display("FAIL mid_tmask: got %b want 1111", t_mask); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({q, t_mask, busy} !== 9'b0) begin n_err++; $display("FAIL mid_async: got %b want 0", {q, t_mask, busy}); end
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ack0, ack1, busy, q, done_count} !== 15'b0) begin n_err++; $display("FAIL mid_held: got %b want 0", {ack0, ack1, busy, q, done_count}); end
        rst_n = 1'b1;
        req0 = 1'b1; mode0 = 1'b0; data0 = 4'b0101;
        req1 = 1'b1; mode1 = 1'b0; data1 = 4'b1010;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++; if ({grant_id, t_mask} !== 5'b00101) begin n_err++; $display("FAIL mid_tie: got %b want 00101", {grant_id, t_mask}); end
        @(negedge clk);
        n_cmp++; if ({ack0, ack1, q} !== 6'b100101) begin n_err++; $display("FAIL mid_after_ack: got %b want 100101", {ack0, ack1, q}); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) run_txn(i[0], 1'b1, 4'b0001);
        n_cmp++; if (done_count !== 8'd255) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", done_count); end
        n_cmp++; if (q !== 4'b0001) begin n_err++; $display("FAIL wrap_q: got %b want 0001", q); end
        run_txn(1'b1, 1'b1, 4'b0001);
        n_cmp++; if (done_count !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", done_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req0 = 1'b0; mode0 = 1'b0; data0 = '0;
        req1 = 1'b0; mode1 = 1'b0; data1 = '0;
        @(negedge clk);
        test_reset();
        test_single_load();
        test_toggle();
        test_round_robin();
        test_null_load();
        test_reset_mid_op();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
